// File: rtl/clk_div_sched_if.sv
// Config and control bundle for the clock-divider tick scheduler.
// The master side configures and starts runs; the slave side (the scheduler) returns ticks and status.
interface clk_div_sched_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_burst;
  logic             start;
  logic             stop;
  logic             tick;
  logic             clk_out;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_div, cfg_burst, start, stop,
    input  cfg_ready, tick, clk_out, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_burst, start, stop,
    output cfg_ready, tick, clk_out, busy, done
  );
endinterface

// File: rtl/clk_div_sched.sv
// Programmable tick scheduler: emits a one-cycle tick every div_q cycles and a divided
// square wave, in continuous or finite-burst runs controlled by start/stop.
module clk_div_sched #(
  parameter int DIV_W       = 16,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 16
) (
  input  logic            clk,
  input  logic            rst,
  clk_div_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [DIV_W-1:0] div_r;
  logic [CNT_W-1:0] burst_r;
  logic [DIV_W-1:0] cnt_r;
  logic [CNT_W-1:0] tick_cnt_r;
  logic             tick_r;
  logic             done_r;
  logic             clk_out_r;

  logic [DIV_W-1:0] div_clamp_s;
  logic [DIV_W-1:0] half_div_s;
  logic [CNT_W-1:0] tick_cnt_inc_s;
  logic             terminal_s;
  logic             last_tick_s;
  logic             level_s;

  // Decode config clamp, terminal count and the final-tick condition of a finite burst.
  always_comb begin
    div_clamp_s    = (bus.cfg_div < DIV_W'(2)) ? DIV_W'(2) : bus.cfg_div;
    half_div_s     = div_r >> 1;
    tick_cnt_inc_s = tick_cnt_r + CNT_W'(1);
    terminal_s     = (cnt_r == (div_r - DIV_W'(1)));
    last_tick_s    = (burst_r != {CNT_W{1'b0}}) && (tick_cnt_inc_s == burst_r);
    level_s        = (cnt_r >= half_div_s);
  end

  assign bus.cfg_ready = (state_r == ST_IDLE);
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.tick      = tick_r;
  assign bus.done      = done_r;
  assign bus.clk_out   = clk_out_r;

  // Scheduler FSM with registered tick, done and divided-level outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      div_r      <= DIV_W'(DEFAULT_DIV);
      burst_r    <= {CNT_W{1'b0}};
      cnt_r      <= {DIV_W{1'b0}};
      tick_cnt_r <= {CNT_W{1'b0}};
      tick_r     <= 1'b0;
      done_r     <= 1'b0;
      clk_out_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tick_r    <= 1'b0;
          done_r    <= 1'b0;
          clk_out_r <= 1'b0;
          if (bus.cfg_valid) begin
            div_r   <= div_clamp_s;
            burst_r <= bus.cfg_burst;
          end
          // A same-cycle config handshake is already reflected in div_r/burst_r for the run.
          if (bus.start && !bus.stop) begin
            state_r    <= ST_RUN;
            cnt_r      <= {DIV_W{1'b0}};
            tick_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {DIV_W{1'b0}};
            tick_cnt_r <= {CNT_W{1'b0}};
            tick_r     <= 1'b0;
            done_r     <= 1'b0;
            clk_out_r  <= 1'b0;
          end else if (terminal_s) begin
            cnt_r      <= {DIV_W{1'b0}};
            tick_r     <= 1'b1;
            tick_cnt_r <= tick_cnt_inc_s;
            if (last_tick_s) begin
              done_r    <= 1'b1;
              state_r   <= ST_DONE;
              clk_out_r <= 1'b0;
            end else begin
              done_r    <= 1'b0;
              clk_out_r <= level_s;
            end
          end else begin
            cnt_r     <= cnt_r + DIV_W'(1);
            tick_r    <= 1'b0;
            done_r    <= 1'b0;
            clk_out_r <= level_s;
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          tick_r    <= 1'b0;
          done_r    <= 1'b0;
          clk_out_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          tick_r    <= 1'b0;
          done_r    <= 1'b0;
          clk_out_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: directed scenarios plus random traffic, every cycle
// compared against a reference model that counts cycles since start.
module tb_clk_div_sched;
  localparam int DIV_W = 16;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  clk_div_sched_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  clk_div_sched #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DEFAULT_DIV(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int check_cnt = 0;
  int err_cnt   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 done-cycle; m_n counts edges since start.
  int m_mode  = 0;
  int m_div   = 16;
  int m_burst = 0;
  int m_n     = 0;
  bit m_tick  = 1'b0;
  bit m_done  = 1'b0;
  bit m_clk   = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_div = 16; m_burst = 0; m_n = 0;
      m_tick = 1'b0; m_done = 1'b0; m_clk = 1'b0;
    end else begin
      m_tick = 1'b0; m_done = 1'b0; m_clk = 1'b0;
      if (m_mode == 0) begin
        if (bus.cfg_valid) begin
          m_div   = (bus.cfg_div < 2) ? 2 : int'(bus.cfg_div);
          m_burst = int'(bus.cfg_burst);
        end
        if (bus.start && !bus.stop) begin
          m_mode = 1;
          m_n    = 0;
        end
      end else if (m_mode == 1) begin
        if (bus.stop) begin
          m_mode = 0;
        end else begin
          m_n++;
          m_tick = (m_n % m_div == 0);
          if (m_tick && m_burst != 0 && (m_n / m_div) == m_burst) begin
            m_done = 1'b1;
            m_mode = 2;
          end else begin
            m_clk = (((m_n - 1) % m_div) >= (m_div / 2));
          end
        end
      end else begin
        m_mode = 0;
      end
    end
  end

  always @(negedge clk) begin
    check_val("tick",      bus.tick,      m_tick);
    check_val("done",      bus.done,      m_done);
    check_val("clk_out",   bus.clk_out,   m_clk);
    check_val("busy",      bus.busy,      (m_mode != 0));
    check_val("cfg_ready", bus.cfg_ready, (m_mode == 0));
  end

  task automatic drive(input bit v, input int d, input int b, input bit s, input bit p);
    bus.cfg_valid = v;
    bus.cfg_div   = DIV_W'(d);
    bus.cfg_burst = CNT_W'(b);
    bus.start     = s;
    bus.stop      = p;
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_only(input int d, input int b);
    drive(1'b1, d, b, 1'b0, 1'b0);
    @(negedge clk);
    idle_cycles(0);
  endtask

  task automatic go(input int n);
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    idle_cycles(n);
  endtask

  task automatic cfg_go(input int d, input int b, input int n);
    drive(1'b1, d, b, 1'b1, 1'b0);
    @(negedge clk);
    idle_cycles(n);
  endtask

  task automatic stop_now();
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    idle_cycles(0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("rst_tick",    bus.tick,      1'b0);
    check_val("rst_busy",    bus.busy,      1'b0);
    check_val("rst_clk_out", bus.clk_out,   1'b0);
    check_val("rst_done",    bus.done,      1'b0);
    check_val("rst_ready",   bus.cfg_ready, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Default divide ratio, continuous run, then stop.
    go(40);
    stop_now();
    idle_cycles(3);

    // Finite burst of 3 at div 5.
    cfg_only(5, 3);
    go(25);

    // Divide ratios 0 and 1 clamp to 2.
    cfg_go(0, 4, 12);
    cfg_go(1, 3, 10);

    // Stop in the exact cycle the counter sits at its terminal value.
    cfg_only(4, 0);
    go(11);
    stop_now();
    check_val("stop_tick",  bus.tick,      1'b0);
    check_val("stop_done",  bus.done,      1'b0);
    check_val("stop_ready", bus.cfg_ready, 1'b1);
    idle_cycles(2);

    // Config and start together; config offered during the run is not accepted.
    cfg_go(7, 0, 10);
    drive(1'b1, 3, 2, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    idle_cycles(20);
    stop_now();

    // start and stop together in idle is ignored; stop alone in idle is ignored.
    drive(1'b0, 0, 0, 1'b1, 1'b1);
    @(negedge clk);
    stop_now();
    idle_cycles(2);

    // Reset mid-burst, then a run at the reverted default ratio.
    cfg_go(6, 10, 20);
    pulse_reset();
    go(40);
    stop_now();

    // Longest finite burst, and a continuous run long enough to wrap the tick counter.
    cfg_go(2, 255, 520);
    cfg_go(2, 0, 600);
    stop_now();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      drive($urandom_range(0, 99) < 25,
            int'($urandom_range(0, 12)),
            (r < 3) ? 0 : int'($urandom_range(1, 6)),
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 99) < 4);
      @(negedge clk);
      if ($urandom_range(0, 999) == 0) pulse_reset();
    end
    idle_cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end
endmodule
